// File: rtl/soma_multi_pkg.sv
// Shared types, opcodes and helpers for the soma_multi add/multiply unit.
package soma_multi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_SOMA = 1'b0;
  localparam logic OP_MULT = 1'b1;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/soma_multi_adder.sv
// (WIDTH+1)-bit adder/subtractor shared by the add path and every multiply step.
module soma_multi_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  always_comb begin
    sum = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/soma_multi_seq.sv
// Handshaked add / radix-2 shift-add multiply unit with full-width result.
// Define SOMA_MULTI_SIGNED_EN for two's-complement operands.
module soma_multi_seq
  import soma_multi_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sel,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   saida
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   saida_q, saida_d;

  logic [WIDTH:0]       adder_a, adder_b, adder_sum;
  logic                 adder_sub;
  logic                 last;

  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
`ifdef SOMA_MULTI_SIGNED_EN
    return {v[WIDTH-1], v};
`else
    return {1'b0, v};
`endif
  endfunction

  function automatic logic [2*WIDTH-1:0] widen(input logic [WIDTH:0] v);
`ifdef SOMA_MULTI_SIGNED_EN
    return {{(WIDTH-1){v[WIDTH]}}, v};
`else
    return {{(WIDTH-1){1'b0}}, v};
`endif
  endfunction

  soma_multi_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (adder_a),
    .b   (adder_b),
    .sub (adder_sub),
    .sum (adder_sum)
  );

  assign last = (cnt_q == LAST_STEP);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    saida_d   = saida_q;
    adder_a   = '0;
    adder_b   = '0;
    adder_sub = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d     = A;
          b_d     = B;
          acc_d   = {{WIDTH{1'b0}}, B};
          cnt_d   = '0;
          state_d = (sel == OP_MULT) ? MUL : ADD;
        end
      end
      ADD: begin
        adder_a = ext(a_q);
        adder_b = ext(b_q);
        saida_d = widen(adder_sum);
        state_d = DONE;
      end
      MUL: begin
        // Multiplier sits in the low half of acc and is consumed LSB first.
        adder_a = ext(acc_q[2*WIDTH-1:WIDTH]);
        adder_b = acc_q[0] ? ext(a_q) : '0;
`ifdef SOMA_MULTI_SIGNED_EN
        adder_sub = last & acc_q[0];
`endif
        acc_d = {adder_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          saida_d = acc_d;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      saida_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      saida_q <= saida_d;
    end
  end

  assign saida = saida_q;

endmodule

// File: tb/tb_soma_multi_seq.sv
// Directed self-checking bench for soma_multi_seq at WIDTH=16.
module tb_soma_multi_seq;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic           sel;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           ready;
  logic           done;
  logic [2*W-1:0] saida;

  int n_cmp = 0;
  int n_err = 0;

  soma_multi_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sel   (sel),
    .A     (A),
    .B     (B),
    .ready (ready),
    .done  (done),
    .saida (saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One operation: checks idle before, latency to done, result, and return to idle.
  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int lat;
    @(negedge clk);
    check_val({tag, "/ready_before"}, 64'(ready), 64'd1);
    start = 1'b1; sel = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "/latency"}, 64'(lat), op ? 64'(W + 1) : 64'd2);
    check_val({tag, "/saida"}, 64'(saida), 64'(exp));
    @(negedge clk);
    check_val({tag, "/done_pulse"}, 64'(done), 64'd0);
    check_val({tag, "/ready_after"}, 64'(ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*W-1:0] exp_add_ffff, exp_mul_ffff, exp_add_8000;
    logic [2*W-1:0] prev;
    int dones, done_cyc;
    logic rdy18, rdy19;

`ifdef SOMA_MULTI_SIGNED_EN
    exp_add_ffff = 32'h0000_0000;
    exp_mul_ffff = 32'h0000_0001;
    exp_add_8000 = 32'hFFFF_0000;
`else
    exp_add_ffff = 32'h0001_0000;
    exp_mul_ffff = 32'hFFFE_0001;
    exp_add_8000 = 32'h0001_0000;
`endif

    rst = 1'b1; start = 1'b0; sel = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check_val("reset/ready", 64'(ready), 64'd1);
    check_val("reset/done", 64'(done), 64'd0);
    check_val("reset/saida", 64'(saida), 64'd0);
    rst = 1'b0;

    run_op("add_2_3", 1'b0, 16'd2, 16'd3, 32'd5);
    run_op("mul_2_3", 1'b1, 16'd2, 16'd3, 32'd6);
    run_op("mul_4_2", 1'b1, 16'd4, 16'd2, 32'd8);
    run_op("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, exp_add_ffff);
    run_op("add_7fff_7fff", 1'b0, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE);
    run_op("add_8000_8000", 1'b0, 16'h8000, 16'h8000, exp_add_8000);
    run_op("mul_ffff_ffff", 1'b1, 16'hFFFF, 16'hFFFF, exp_mul_ffff);
    run_op("mul_00ff_0101", 1'b1, 16'h00FF, 16'h0101, 32'h0000_FFFF);
    run_op("mul_zero", 1'b1, 16'h0000, 16'h1234, 32'h0000_0000);
    run_op("add_zero", 1'b0, 16'h0000, 16'h0000, 32'h0000_0000);
    run_op("mul_8000_8000", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    prev = 32'h4000_0000;

    // Start pulses during MUL and DONE must be dropped.
    @(negedge clk);
    start = 1'b1; sel = 1'b1; A = 16'd5; B = 16'd7;
    @(negedge clk);
    start = 1'b0;
    dones = 0; done_cyc = 0; rdy18 = 1'b0; rdy19 = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (cyc == 10) check_val("ignore/saida_hold", 64'(saida), 64'(prev));
      if (cyc == 18) rdy18 = ready;
      if (cyc == 19) rdy19 = ready;
      case (cyc)
        5:  begin start = 1'b1; sel = 1'b0; A = 16'd9; B = 16'd9; end
        6:  begin start = 1'b0; A = 16'd100; B = 16'd200; end
        17: begin start = 1'b1; sel = 1'b1; A = 16'd3; B = 16'd3; end
        18: start = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    check_val("ignore/done_count", 64'(dones), 64'd1);
    check_val("ignore/done_cycle", 64'(done_cyc), 64'(W + 1));
    check_val("ignore/saida", 64'(saida), 64'd35);
    check_val("ignore/ready_n18", 64'(rdy18), 64'd1);
    check_val("ignore/ready_n19", 64'(rdy19), 64'd1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; sel = 1'b1; A = 16'h1234; B = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 8; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst/ready", 64'(ready), 64'd1);
    check_val("midrst/saida", 64'(saida), 64'd0);
    check_val("midrst/done", 64'(done), 64'd0);
    dones = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check_val("midrst/no_done", 64'(dones), 64'd0);
    run_op("add_4_2", 1'b0, 16'd4, 16'd2, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/soma_multi_seq.md
# soma_multi_seq

Parametrised, handshaked successor to the combinational add/multiply unit: one operator block selects addition or multiplication via `sel`, but multiplication is a multi-cycle radix-2 shift-add engine sharing a single adder. Operands are captured on a start handshake; the result is delivered full-width (no truncation) with a one-cycle `done` pulse. The block sits in the datapath wherever a low-area arithmetic unit is acceptable in exchange for variable latency.

## Interface
- `WIDTH`, 16: operand width in bits, ≥ 2.
- `clk`  in  1  rising-edge clock, single domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `sel`  in  1  operation: 0 = add (soma), 1 = multiply.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `ready`  out  1  block idle, can accept `start`.
- `done`  out  1  one-cycle pulse, `saida` valid and new.
- `saida`  out  2*WIDTH  result; holds last value until next `done`.

## Operation
- States: IDLE, ADD, MUL, DONE. Reset → IDLE, `ready`=1, `done`=0, `saida`=0, internal counter=0.
- IDLE: `start`&`ready` captures `A`, `B`, `sel` into internal registers; `sel`=0 → ADD, `sel`=1 → MUL. Inputs are ignored at all other times.
- ADD (1 cycle): `saida` ← zero-extended (A+B) computed at WIDTH+1 bits; carry lands in bit WIDTH, upper bits 0. → DONE.
- MUL (exactly WIDTH cycles, counter 0..WIDTH-1): each cycle, if multiplier LSB=1, add multiplicand to upper accumulator half (WIDTH+1-bit add); shift accumulator right by 1. After last step `saida` ← accumulator. → DONE. No early termination: latency is data-independent.
- DONE (1 cycle): `done`=1, `ready`=0. → IDLE.
- `ready`=1 only in IDLE; `start` while `ready`=0 is dropped, not queued.
- Operand changes after capture have no effect on the running operation.
- `rst` asserted in any state, including mid-MUL: next cycle IDLE, `saida`=0, `done`=0, no partial result exposed.
- Zero operands follow the normal path and timing (no shortcut).

## Timing
- Handshake accepted at the rising edge ending cycle N.
- Add: ADD in N+1, `done`=1 in N+2, `ready`=1 in N+3.
- Multiply: MUL in N+1..N+WIDTH, `done`=1 in N+WIDTH+1, `ready`=1 in N+WIDTH+2.
- Back-to-back throughput: one add per 3 cycles, one multiply per WIDTH+2 cycles.
- `saida` changes only on the edge that enters DONE.

## Configuration
- `SOMA_MULTI_SIGNED_EN` defined: operands are two's complement. Add sign-extends both operands to 2*WIDTH before summing. Multiply uses sign-extended partial products; on the final step, if multiplier MSB=1, the multiplicand is subtracted instead of added. The product is the exact 2*WIDTH signed result. Latency is identical.
- Not defined: all arithmetic is unsigned as described in Operation.

## Structure
- Package `soma_multi_pkg`: state enum (IDLE, ADD, MUL, DONE), op constants `OP_SOMA`=1'b0, `OP_MULT`=1'b1, and counter-width function clog2(WIDTH).
- Sub-module `soma_multi_adder`: (WIDTH+1)-bit adder/subtractor with `sub` input, shared by ADD and every MUL step. The top level holds the FSM, operand/accumulator registers and counter.

## Test plan
- WIDTH=16, A=2, B=3, sel=0, start at cycle N → `done` at N+2, `saida`=5, `ready` back at N+3.
- A=2, B=3, sel=1 → `done` exactly at N+17, `saida`=6; then A=4, B=2, sel=1 → `saida`=8.
- A=16'hFFFF, B=16'h0001, sel=0 → `saida`=32'h0001_0000 (unsigned); with `SOMA_MULTI_SIGNED_EN`, `saida`=32'h0000_0000.
- A=B=16'hFFFF, sel=1 → unsigned `saida`=32'hFFFE_0001; signed build → `saida`=32'h0000_0001. Also A=16'h8000, B=16'h8000 signed → 32'h4000_0000.
- `start` pulsed with new operands during MUL cycles N+5 and during DONE → ignored; result matches the original operands, and exactly one `done` is produced.
- `rst` asserted at N+8 of a multiply → next cycle `ready`=1, `saida`=0, no `done`; a fresh add of 4+2 then yields 6 with normal timing.
